// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_pkg
// Purpose  : Shared types and helpers for the memory-access stage: the
//            decoded instruction enum, access-size type, load/store
//            predicates, size mask and load extension.
// Revision : 1.0  initial release
// ============================================================================
package mem_access_pkg;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDI = 4'd1,
        OP_LD   = 4'd2,
        OP_LB   = 4'd3,
        OP_LH   = 4'd4,
        OP_LW   = 4'd5,
        OP_LBU  = 4'd6,
        OP_LHU  = 4'd7,
        OP_LWU  = 4'd8,
        OP_SD   = 4'd9,
        OP_SB   = 4'd10,
        OP_SH   = 4'd11,
        OP_SW   = 4'd12
    } instruction_type;

    typedef enum logic [2:0] {
        MSIZE_B = 3'd0,
        MSIZE_H = 3'd1,
        MSIZE_W = 3'd2,
        MSIZE_D = 3'd3
    } msize_t;

    function automatic logic op_is_load(input instruction_type op);
        return (op == OP_LD) || (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWU);
    endfunction

    function automatic logic op_is_store(input instruction_type op);
        return (op == OP_SD) || (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_mem(input instruction_type op);
        return op_is_load(op) || op_is_store(op);
    endfunction

    function automatic logic op_is_signed(input instruction_type op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    endfunction

    function automatic msize_t op_size(input instruction_type op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return MSIZE_B;
            OP_LH, OP_LHU, OP_SH: return MSIZE_H;
            OP_LW, OP_LWU, OP_SW: return MSIZE_W;
            default:              return MSIZE_D;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input msize_t size);
        case (size)
            MSIZE_B: return 8'h01;
            MSIZE_H: return 8'h03;
            MSIZE_W: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Truncate the already lane-aligned raw value to the access size and
    // sign- or zero-extend it back to XLEN.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                               input msize_t size,
                                               input logic sgn);
        case (size)
            MSIZE_B: return {{56{sgn & raw[7]}},  raw[7:0]};
            MSIZE_H: return {{48{sgn & raw[15]}}, raw[15:0]};
            MSIZE_W: return {{32{sgn & raw[31]}}, raw[31:0]};
            default: return raw;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_if
// Purpose  : Bundles the execute-side input handshake, the writeback output
//            handshake and the data-bus request/response of the stage.
// Modports : slave  - the memory-access stage itself
//            master - the surrounding pipeline / bus environment
// Revision : 1.0  initial release
// ============================================================================
interface mem_access_if;
    import mem_access_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    instruction_type      in_op;
    logic [XLEN-1:0]      in_result;
    logic [XLEN-1:0]      in_wdata;
    logic [REG_W-1:0]     in_rd;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_result;
    logic [REG_W-1:0]     out_rd;
    logic                 out_misaligned;

    logic                 dreq_valid;
    logic [XLEN-1:0]      dreq_addr;
    msize_t               dreq_size;
    logic [7:0]           dreq_strobe;
    logic [XLEN-1:0]      dreq_data;
    logic                 dresp_ok;
    logic [XLEN-1:0]      dresp_data;

    modport slave (
        input  in_valid, in_op, in_result, in_wdata, in_rd,
        output in_ready,
        output out_valid, out_result, out_rd, out_misaligned,
        input  out_ready,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dresp_ok, dresp_data
    );

    modport master (
        output in_valid, in_op, in_result, in_wdata, in_rd,
        input  in_ready,
        input  out_valid, out_result, out_rd, out_misaligned,
        output out_ready,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dresp_ok, dresp_data
    );

endinterface
`default_nettype wire

// File: rtl/mem_access_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_align
// Purpose  : Combinational lane alignment for one access: byte strobes,
//            lane-shifted store data, load extraction/extension and the
//            misalignment check.
// Ports    : op, off          - access op and byte offset addr[2:0]
//            wdata, rdata     - raw store data / raw 8-byte bus read data
//            size, strobe     - access size and byte enables (0 for loads)
//            wdata_shifted    - store data moved to its byte lane
//            mem_result       - extended load value, 0 for stores
//            misaligned       - offset not a multiple of the access size
// Revision : 1.0  initial release
// ============================================================================
module mem_access_align
    import mem_access_pkg::*;
(
    input  instruction_type  op,
    input  logic [2:0]       off,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rdata,
    output msize_t           size,
    output logic [7:0]       strobe,
    output logic [XLEN-1:0]  wdata_shifted,
    output logic [XLEN-1:0]  mem_result,
    output logic             misaligned
);

    logic [5:0]      w_bit_shift;
    logic [XLEN-1:0] w_raw;

    assign size          = op_size(op);
    assign w_bit_shift   = {off, 3'b000};
    assign strobe        = op_is_store(op) ? (size_mask(size) << off) : 8'h00;
    assign wdata_shifted = wdata << w_bit_shift;
    assign w_raw         = rdata >> w_bit_shift;
    assign mem_result    = op_is_store(op) ? '0 : extend(w_raw, size, op_is_signed(op));

    always_comb begin
        misaligned = 1'b0;
        case (size)
            MSIZE_H: misaligned = off[0];
            MSIZE_W: misaligned = |off[1:0];
            MSIZE_D: misaligned = |off;
            default: misaligned = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : Memory-access pipeline stage. Passes ALU results through,
//            issues one data-bus request per aligned load/store and stalls
//            until the bus responds, then registers the result for
//            writeback. Misaligned accesses are suppressed and flagged.
// Ports    : clk, rst_n (async, active-low)
//            bus (mem_access_if.slave): execute input handshake, writeback
//            output handshake, data-bus request/response
// Revision : 1.0  initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    mem_access_if.slave    bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    instruction_type   r_op;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [REG_W-1:0]  r_rd;

    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_result;
    logic [REG_W-1:0]  r_out_rd;
    logic              r_out_mis;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_in_req;
    logic              w_latch;
    logic              w_load_out;
    logic [XLEN-1:0]   w_next_result;
    logic [REG_W-1:0]  w_next_rd;
    logic              w_next_mis;

    instruction_type   w_al_op;
    logic [2:0]        w_al_off;
    msize_t            w_size;
    logic [7:0]        w_strobe;
    logic [XLEN-1:0]   w_wdata_shifted;
    logic [XLEN-1:0]   w_mem_result;
    logic              w_misaligned;

    assign w_in_req   = (r_state == ST_REQ);
    assign w_in_ready = !w_in_req && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // One aligner serves both phases: in IDLE it checks the incoming op for
    // misalignment, in REQ it works on the latched transaction.
    assign w_al_op  = w_in_req ? r_op        : bus.in_op;
    assign w_al_off = w_in_req ? r_addr[2:0] : bus.in_result[2:0];

    mem_access_align u_align (
        .op            (w_al_op),
        .off           (w_al_off),
        .wdata         (r_wdata),
        .rdata         (bus.dresp_data),
        .size          (w_size),
        .strobe        (w_strobe),
        .wdata_shifted (w_wdata_shifted),
        .mem_result    (w_mem_result),
        .misaligned    (w_misaligned)
    );

    always_comb begin
        w_state_next  = r_state;
        w_latch       = 1'b0;
        w_load_out    = 1'b0;
        w_next_result = '0;
        w_next_rd     = bus.in_rd;
        w_next_mis    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!op_is_mem(bus.in_op)) begin
                        w_load_out    = 1'b1;
                        w_next_result = bus.in_result;
                    end else if (w_misaligned) begin
                        w_load_out = 1'b1;
                        w_next_mis = 1'b1;
                    end else begin
                        w_latch      = 1'b1;
                        w_state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus.dresp_ok) begin
                    w_load_out    = 1'b1;
                    w_next_result = w_mem_result;
                    w_next_rd     = r_rd;
                    w_state_next  = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The output slot is always free while in REQ (accept required
    // !out_valid || out_ready), so a bus response never overwrites a
    // result still waiting for writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_ADD;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rd         <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_rd     <= '0;
            r_out_mis    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_op    <= bus.in_op;
                r_addr  <= bus.in_result;
                r_wdata <= bus.in_wdata;
                r_rd    <= bus.in_rd;
            end
            if (w_load_out) begin
                r_out_valid  <= 1'b1;
                r_out_result <= w_next_result;
                r_out_rd     <= w_next_rd;
                r_out_mis    <= w_next_mis;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_result     = r_out_result;
    assign bus.out_rd         = r_out_rd;
    assign bus.out_misaligned = r_out_mis;

    // Request fields are qualified by state so they read 0 outside REQ and
    // drop together with the asynchronous reset.
    assign bus.dreq_valid  = w_in_req;
    assign bus.dreq_addr   = w_in_req ? r_addr          : '0;
    assign bus.dreq_size   = w_in_req ? w_size          : MSIZE_B;
    assign bus.dreq_strobe = w_in_req ? w_strobe        : 8'h00;
    assign bus.dreq_data   = w_in_req ? w_wdata_shifted : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Directed self-checking bench for mem_access.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access;
    import mem_access_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mem_access_if bus ();

    mem_access u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_op      = OP_ADD;
        bus.in_result  = '0;
        bus.in_wdata   = '0;
        bus.in_rd      = '0;
        bus.out_ready  = 1'b1;
        bus.dresp_ok   = 1'b0;
        bus.dresp_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_result !== 64'h0 || bus.out_rd !== 5'd0 ||
            bus.out_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: valid=%b result=%h rd=%0d mis=%b, required 0/0/0/0",
                     bus.out_valid, bus.out_result, bus.out_rd, bus.out_misaligned);
        end
        checks++;
        if (bus.dreq_valid !== 1'b0 || bus.dreq_addr !== 64'h0 || bus.dreq_strobe !== 8'h00 ||
            bus.dreq_data !== 64'h0 || bus.dreq_size !== MSIZE_B) begin
            errors++;
            $display("FAIL reset_dreq: valid=%b addr=%h strobe=%h data=%h, required all 0",
                     bus.dreq_valid, bus.dreq_addr, bus.dreq_strobe, bus.dreq_data);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu();
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_ADDI;
        bus.in_result = 64'h1234;
        bus.in_rd     = 5'd5;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 64'h1234 || bus.out_rd !== 5'd5 ||
            bus.out_misaligned !== 1'b0) begin
            errors++;
            $display("FAIL alu_out: valid=%b result=%h rd=%0d mis=%b, required 1/1234/5/0",
                     bus.out_valid, bus.out_result, bus.out_rd, bus.out_misaligned);
        end
        checks++;
        if (bus.dreq_valid !== 1'b0) begin
            errors++;
            $display("FAIL alu_no_dreq: dreq_valid=%b, required 0", bus.dreq_valid);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL alu_retire: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_load_byte();
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_LB;
        bus.in_result = 64'h1003;
        bus.in_rd     = 5'd7;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.dreq_valid !== 1'b1 || bus.dreq_addr !== 64'h1003 || bus.dreq_size !== MSIZE_B ||
            bus.dreq_strobe !== 8'h00 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL lb_req: valid=%b addr=%h size=%0d strobe=%h in_ready=%b, required 1/1003/0/00/0",
                     bus.dreq_valid, bus.dreq_addr, bus.dreq_size, bus.dreq_strobe, bus.in_ready);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus.dreq_valid !== 1'b1 || bus.dreq_addr !== 64'h1003 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lb_wait: dreq_valid=%b addr=%h out_valid=%b, required 1/1003/0",
                     bus.dreq_valid, bus.dreq_addr, bus.out_valid);
        end
        bus.dresp_ok   = 1'b1;
        bus.dresp_data = 64'h00000000_80000000;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lb_resp_cycle: out_valid=%b, required 0", bus.out_valid);
        end
        step();
        bus.dresp_ok = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 64'hFFFFFFFF_FFFFFF80 ||
            bus.out_rd !== 5'd7 || bus.dreq_valid !== 1'b0) begin
            errors++;
            $display("FAIL lb_result: valid=%b result=%h rd=%0d dreq=%b, required 1/ffffffffffffff80/7/0",
                     bus.out_valid, bus.out_result, bus.out_rd, bus.dreq_valid);
        end
        step();
    endtask

    task automatic test_store_half();
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_SH;
        bus.in_result = 64'h2006;
        bus.in_wdata  = 64'hABCD;
        bus.in_rd     = 5'd9;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.dreq_valid !== 1'b1 || bus.dreq_strobe !== 8'hC0 ||
            bus.dreq_data !== 64'hABCD0000_00000000 || bus.dreq_size !== MSIZE_H) begin
            errors++;
            $display("FAIL sh_req: valid=%b strobe=%h data=%h size=%0d, required 1/c0/abcd000000000000/1",
                     bus.dreq_valid, bus.dreq_strobe, bus.dreq_data, bus.dreq_size);
        end
        bus.dresp_ok   = 1'b1;
        bus.dresp_data = 64'hFFFFFFFF_FFFFFFFF;
        step();
        bus.dresp_ok = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 64'h0 || bus.out_rd !== 5'd9) begin
            errors++;
            $display("FAIL sh_result: valid=%b result=%h rd=%0d, required 1/0/9",
                     bus.out_valid, bus.out_result, bus.out_rd);
        end
        step();
    endtask

    task automatic test_misaligned();
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_LW;
        bus.in_result = 64'h3002;
        bus.in_rd     = 5'd3;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_misaligned !== 1'b1 || bus.out_result !== 64'h0 ||
            bus.out_rd !== 5'd3) begin
            errors++;
            $display("FAIL lw_misaligned: valid=%b mis=%b result=%h rd=%0d, required 1/1/0/3",
                     bus.out_valid, bus.out_misaligned, bus.out_result, bus.out_rd);
        end
        checks++;
        if (bus.dreq_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lw_no_req: dreq_valid=%b in_ready=%b, required 0/1",
                     bus.dreq_valid, bus.in_ready);
        end
        step();
    endtask

    task automatic test_load_variants();
        instruction_type ops  [6] = '{OP_LHU, OP_LH, OP_LW, OP_LWU, OP_LD, OP_LBU};
        logic [63:0]     addrs[6] = '{64'h4002, 64'h4002, 64'h4004, 64'h4004, 64'h4000, 64'h4007};
        logic [63:0]     data [6] = '{64'h00000000_F00D0000, 64'h00000000_F00D0000,
                                      64'h87654321_00000000, 64'h87654321_00000000,
                                      64'h0123456789ABCDEF,  64'hFE000000_00000000};
        logic [63:0]     exp  [6] = '{64'h00000000_0000F00D, 64'hFFFFFFFF_FFFFF00D,
                                      64'hFFFFFFFF_87654321, 64'h00000000_87654321,
                                      64'h0123456789ABCDEF,  64'h00000000_000000FE};
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_op     = ops[i];
            bus.in_result = addrs[i];
            bus.in_rd     = 5'(i + 10);
            step();
            bus.in_valid   = 1'b0;
            bus.dresp_ok   = 1'b1;
            bus.dresp_data = data[i];
            step();
            bus.dresp_ok = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== exp[i] || bus.out_rd !== 5'(i + 10)) begin
                errors++;
                $display("FAIL load_variant_%0d: valid=%b result=%h rd=%0d, required 1/%h/%0d",
                         i, bus.out_valid, bus.out_result, bus.out_rd, exp[i], i + 10);
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_ADD;
        bus.in_result = 64'h11;
        bus.in_rd     = 5'd1;
        step();
        bus.in_result = 64'h22;
        bus.in_rd     = 5'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 64'h11 ||
                bus.out_rd !== 5'd1) begin
                errors++;
                $display("FAIL bp_hold_%0d: in_ready=%b valid=%b result=%h rd=%0d, required 0/1/11/1",
                         i, bus.in_ready, bus.out_valid, bus.out_result, bus.out_rd);
            end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_result !== 64'h11) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b result=%h, required 1/11",
                     bus.in_ready, bus.out_result);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 64'h22 || bus.out_rd !== 5'd2) begin
            errors++;
            $display("FAIL bp_second: valid=%b result=%h rd=%0d, required 1/22/2",
                     bus.out_valid, bus.out_result, bus.out_rd);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] vals[4] = '{64'hA0, 64'hB1, 64'hC2, 64'hD3};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_op     = OP_ADDI;
            bus.in_result = vals[i];
            bus.in_rd     = 5'(20 + i);
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== vals[i] || bus.out_rd !== 5'(20 + i)) begin
                errors++;
                $display("FAIL b2b_%0d: valid=%b result=%h rd=%0d, required 1/%h/%0d",
                         i, bus.out_valid, bus.out_result, bus.out_rd, vals[i], 20 + i);
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_req();
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_LD;
        bus.in_result = 64'h5000;
        bus.in_rd     = 5'd4;
        step();
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.dreq_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: dreq_valid=%b, required 1", bus.dreq_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dreq_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.dreq_addr !== 64'h0) begin
            errors++;
            $display("FAIL rst_async: dreq_valid=%b out_valid=%b addr=%h, required 0/0/0",
                     bus.dreq_valid, bus.out_valid, bus.dreq_addr);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.dreq_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: in_ready=%b dreq_valid=%b out_valid=%b, required 1/0/0",
                     bus.in_ready, bus.dreq_valid, bus.out_valid);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_alu();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_load_variants();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access.md
# mem_access

Memory-access stage directly downstream of the execute ALU. It takes one ALU-completed instruction at a time and issues a single data-bus request for loads and stores. Loads are lane-aligned and sign/zero-extended; non-memory results pass straight through. It then presents a registered result to writeback. A memory operation stalls the stage until the bus responds.

## Interface
Parameters:
- none; widths come from `common`.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  execute result valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_op`  in  instruction_type  decoded op.
- `in_result`  in  64  ALU result (effective address for LD/LB/LH/LW/LBU/LHU/LWU/SD/SB/SH/SW).
- `in_wdata`  in  64  store data (rs2 value).
- `in_rd`  in  5  destination register.
- `out_valid`  out  1  result valid to writeback.
- `out_ready`  in  1  writeback accepts.
- `out_result`  out  64  final value for rd.
- `out_rd`  out  5  destination register.
- `out_misaligned`  out  1  access was misaligned and suppressed.
- `dreq_valid`  out  1  bus request.
- `dreq_addr`  out  64  byte address (unaligned-to-8 allowed).
- `dreq_size`  out  3  msize_t: 0=B, 1=H, 2=W, 3=D.
- `dreq_strobe`  out  8  byte write enables, 0 for loads.
- `dreq_data`  out  64  lane-shifted store data.
- `dresp_ok`  in  1  bus completion.
- `dresp_data`  in  64  raw 8-byte-lane read data.

## Operation
- FSM states: IDLE and REQ.
- In IDLE, `in_ready = !out_valid || out_ready`.
- In REQ, `in_ready` = 0.
- Accept = `in_valid && in_ready`.
- Non-memory op accepted: the output register loads `in_result` and `in_rd`, with `out_misaligned`=0. The FSM stays in IDLE.
- Memory op accepted: latch op, addr, wdata and rd.
  - Misaligned means `addr[2:0]` is not a multiple of the size (H: bit0; W: bits1:0; D: bits2:0).
  - If misaligned: no bus request. The output loads result=0, `out_misaligned`=1, and the FSM stays in IDLE.
  - Otherwise the FSM goes to REQ.
- In REQ:
  - `dreq_valid`=1, with all `dreq_*` fields stable until `dresp_ok`.
  - Let off = `addr[2:0]`.
  - `dreq_strobe` = (store ? size_mask << off : 0), where size_mask is 0x01/0x03/0x0F/0xFF.
  - `dreq_data` = `wdata << (8*off)`.
- On `dresp_ok` in REQ:
  - Loads: raw = `dresp_data >> (8*off)`, truncated to the size. LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD takes the full 64 bits.
  - Stores: result = 0 and rd passes through unchanged.
  - The output register loads, and the FSM returns to IDLE.
- `dresp_ok` is ignored outside REQ.
- Output register:
  - `out_valid` sets on load and clears on `out_ready` when no new load occurs in the same cycle.
  - Contents are held while `out_valid && !out_ready`.
- Reset values: state=IDLE; `out_valid`=0; `out_result`=0; `out_rd`=0; `out_misaligned`=0; `dreq_valid`=0; all other `dreq_*` outputs 0.

## Timing
- Non-memory or misaligned op accepted at cycle N: `out_valid`=1 at N+1.
- Memory op accepted at N: `dreq_valid`=1 from N+1. With `dresp_ok` at cycle M (M ≥ N+1), `out_valid`=1 at M+1.
  - Minimum memory latency is 2 cycles.
  - REQ holds indefinitely while `dresp_ok`=0.
- Simultaneous `out_ready` and accept in IDLE: the old result retires and the new one appears at N+1. No bubble, no duplicate.
- Back-to-back non-memory ops with `out_ready`=1 give one result per cycle.
- `rst_n` low mid-REQ: `dreq_valid` drops immediately (asynchronous) and the transaction is abandoned. The bus tolerates the abandoned request.

## Structure
- `msize_t` and the size-mask/extend helper functions go in `common`. The load/store op subsets go in `instruction` as helper predicates.
- Sub-module `mem_align`: purely combinational. It produces strobe, shifted write data, load extraction/extension and the misalignment check. It is instantiated once.

## Test plan
- ADDI result 0x1234 and rd=5 in, `out_ready`=1 → `out_valid` next cycle with result 0x1234 and rd 5; no `dreq_valid`.
- LB addr 0x1003, `dresp_data` 0x00000000_80000000 after a 3-cycle wait → size 0, result 0xFFFFFFFF_FFFFFF80, `out_valid` on the cycle after `dresp_ok`.
- SH addr 0x2006, wdata 0xABCD → strobe 0xC0, data 0xABCD0000_00000000, result 0.
- LW addr 0x3002 → `out_misaligned`=1, result 0, no bus request.
- `out_ready` held 0 for 4 cycles with a new `in_valid` → `in_ready`=0, output stable. Release → both results delivered in order, none lost.
- Reset asserted two cycles into REQ → `dreq_valid` and `out_valid` are 0 immediately; after release the state is IDLE and `in_ready`=1.
